// File: rtl/uart_prog_loader.sv
// UART boot loader: programs memory regions from a host, holding the core in reset until done.
// Optional LOADER_TIMEOUT_EN: auto-boot if the host stays silent in the first RX_SIZE.
module uart_prog_loader #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_busy_i,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wd_o,
  output logic        core_reset_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    S_GREET, S_RX_SIZE, S_ECHO_SIZE, S_RX_DATA, S_ACK, S_RX_ADDR, S_RUN
  } state_t;

  typedef enum logic [1:0] {TX_WAIT, TX_VLD, TX_GAP} tx_ph_t;

  localparam logic [255:0] GREET_S = "ready for flash starting from 0x";
  localparam logic [255:0] ACK_S1  = {120'd0, "finished write 0x"};
  localparam logic [255:0] ACK_S2  = {72'd0, " bytes starting from 0x"};

  // k = 0 selects the most significant nibble
  function automatic logic [7:0] hex_chr(input logic [31:0] v, input logic [2:0] k);
    logic [3:0] n;
    n = 4'(v >> {3'd7 - k, 2'b00});
    hex_chr = (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
  endfunction

  // Character i of a len-byte string right-aligned in s
  function automatic logic [7:0] str_chr(input logic [255:0] s, input logic [5:0] len,
                                         input logic [5:0] i);
    str_chr = 8'(s >> {len - 6'd1 - i, 3'b000});
  endfunction

  state_t      state_q, state_d;
  tx_ph_t      tx_ph_q;
  logic [5:0]  idx_q;
  logic [31:0] addr_q, size_q, word_q, cnt_q;
  logic [31:0] rx_word, wa;
  logic [5:0]  tx_len;
  logic [7:0]  tx_chr;
  logic        is_tx, is_rx, tx_fire, tx_end, rx_take, rx_full, wr_fire, to_hit;

  assign rx_word = {word_q[23:0], rx_data_i};
  assign wa      = addr_q + cnt_q;
  assign is_tx   = (state_q == S_GREET) || (state_q == S_ECHO_SIZE) || (state_q == S_ACK);
  assign is_rx   = (state_q == S_RX_SIZE) || (state_q == S_RX_ADDR);
  assign tx_fire = is_tx && (tx_ph_q == TX_WAIT) && !tx_busy_i;
  assign tx_end  = is_tx && (tx_ph_q == TX_GAP) && (idx_q == tx_len);
  assign rx_take = is_rx && rx_valid_i;
  assign rx_full = rx_take && (idx_q == 6'd3);
  assign wr_fire = (state_q == S_RX_DATA) && (cnt_q != size_q) && rx_valid_i;

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] idle_q;
  logic        idle_en_q;

  assign to_hit = idle_en_q && (state_q == S_RX_SIZE) && !rx_valid_i &&
                  (idle_q == TIMEOUT_CYCLES - 32'd1);

  // Any received byte means a host is present: never auto-boot after that
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_q    <= 32'd0;
      idle_en_q <= 1'b1;
    end else if (rx_valid_i) begin
      idle_en_q <= 1'b0;
    end else if (idle_en_q && (state_q == S_RX_SIZE)) begin
      idle_q <= idle_q + 32'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    tx_len = 6'd0;
    tx_chr = 8'h00;
    case (state_q)
      S_GREET: begin
        tx_len = 6'd40;
        tx_chr = (idx_q < 6'd32) ? str_chr(GREET_S, 6'd32, idx_q)
                                 : hex_chr(addr_q, 3'(idx_q - 6'd32));
      end
      S_ECHO_SIZE: begin
        tx_len = 6'd4;
        tx_chr = 8'(size_q >> {~idx_q[1:0], 3'b000});
      end
      S_ACK: begin
        tx_len = 6'd57;
        if (idx_q < 6'd17)      tx_chr = str_chr(ACK_S1, 6'd17, idx_q);
        else if (idx_q < 6'd25) tx_chr = hex_chr(size_q, 3'(idx_q - 6'd17));
        else if (idx_q < 6'd48) tx_chr = str_chr(ACK_S2, 6'd23, idx_q - 6'd25);
        else if (idx_q < 6'd56) tx_chr = hex_chr(addr_q, 3'(idx_q - 6'd48));
        else                    tx_chr = 8'h0A;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GREET:     if (tx_end) state_d = S_RX_SIZE;
      S_RX_SIZE:   if (rx_full) state_d = S_ECHO_SIZE;
                   else if (to_hit) state_d = S_RUN;
      S_ECHO_SIZE: if (tx_end) state_d = (size_q == 32'd0) ? S_ACK : S_RX_DATA;
      // Leave one cycle after the last byte so its write strobe stays inside RX_DATA
      S_RX_DATA:   if (cnt_q == size_q) state_d = S_ACK;
      S_ACK:       if (tx_end) state_d = S_RX_ADDR;
      S_RX_ADDR:   if (rx_full) state_d = (rx_word == 32'd0) ? S_RUN : S_GREET;
      default:     ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_GREET;
      tx_ph_q      <= TX_WAIT;
      idx_q        <= 6'd0;
      addr_q       <= 32'd0;
      size_q       <= 32'd0;
      word_q       <= 32'd0;
      cnt_q        <= 32'd0;
      tx_valid_o   <= 1'b0;
      tx_data_o    <= 8'h00;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= 32'd0;
      mem_be_o     <= 4'b0000;
      mem_wd_o     <= 32'd0;
      core_reset_o <= 1'b1;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_valid_o   <= 1'b0;
      mem_we_o     <= 1'b0;
      core_reset_o <= (state_d != S_RUN);
      done_o       <= (state_d == S_RUN);

      case (tx_ph_q)
        TX_WAIT: if (tx_fire) begin
          tx_valid_o <= 1'b1;
          tx_data_o  <= tx_chr;
          idx_q      <= idx_q + 6'd1;
          tx_ph_q    <= TX_VLD;
        end
        TX_VLD:  tx_ph_q <= TX_GAP;
        default: tx_ph_q <= TX_WAIT;
      endcase

      if (rx_take) begin
        word_q <= rx_word;
        idx_q  <= idx_q + 6'd1;
      end
      if (rx_full && (state_q == S_RX_SIZE)) size_q <= rx_word;
      if (rx_full && (state_q == S_RX_ADDR) && (rx_word != 32'd0)) addr_q <= rx_word;

      if (state_q == S_ECHO_SIZE) cnt_q <= 32'd0;
      if (wr_fire) begin
        mem_we_o   <= 1'b1;
        mem_addr_o <= {wa[31:2], 2'b00};
        mem_be_o   <= 4'b0001 << wa[1:0];
        mem_wd_o   <= {4{rx_data_i}};
        cnt_q      <= cnt_q + 32'd1;
      end

      if (state_d != state_q) begin
        idx_q   <= 6'd0;
        tx_ph_q <= TX_WAIT;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: random-latency UART host model, expected text/writes built from the protocol.
module tb_uart_prog_loader;
  localparam logic [31:0] TO = 32'd1000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_busy_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wd_o;
  logic        core_reset_o;
  logic        done_o;

  uart_prog_loader #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_busy_i(tx_busy_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wd_o(mem_wd_o),
    .core_reset_o(core_reset_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;
  logic [7:0]  txq[$];
  logic [67:0] wrq[$];
  logic [7:0]  pl[$];
  int   busy_cnt = 0;
  logic hold_busy = 1'b0;
  logic busy_s;
  logic prev_v = 1'b0, prev_we = 1'b0;
  int   viol_busy = 0, viol_vw = 0, viol_wew = 0, viol_wecore = 0;

  assign tx_busy_i = hold_busy || (busy_cnt != 0);

  always @(posedge clk_i) busy_s <= tx_busy_i;

  // Host-side uart_tx stand-in and memory write monitor
  always @(negedge clk_i) begin
    if (rst_i) begin
      busy_cnt = 0; prev_v = 1'b0; prev_we = 1'b0;
    end else begin
      if (tx_valid_o) begin
        txq.push_back(tx_data_o);
        if (busy_s) viol_busy++;
        if (prev_v) viol_vw++;
        busy_cnt = $urandom_range(1, 12);
      end else if (busy_cnt != 0) busy_cnt--;
      if (mem_we_o) begin
        wrq.push_back({mem_addr_o, mem_be_o, mem_wd_o});
        if (prev_we) viol_wew++;
        if (!core_reset_o) viol_wecore++;
      end
      prev_v = tx_valid_o; prev_we = mem_we_o;
    end
  end

  task automatic wait_tx(input int n);
    int c = 0;
    while (txq.size() < n && c < 30000) begin @(negedge clk_i); c++; end
    tests++;
    if (txq.size() < n) begin
      fails++; $display("FAIL wait_tx: got %0d bytes, need %0d", txq.size(), n);
    end
  endtask

  function automatic string pop_str(input int n);
    string s = "";
    for (int i = 0; i < n && txq.size() > 0; i++) s = {s, $sformatf("%c", txq.pop_front())};
    return s;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_i); rx_data_i = b; rx_valid_i = 1'b1;
    @(negedge clk_i); rx_valid_i = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk_i);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic do_reset;
    @(negedge clk_i); rst_i = 1'b1; rx_valid_i = 1'b0; hold_busy = 1'b0;
    repeat (3) @(negedge clk_i);
    txq.delete(); wrq.delete();
    rst_i = 1'b0;
  endtask

  task automatic expect_greet(input logic [31:0] a);
    string got, exp;
    exp = $sformatf("ready for flash starting from 0x%08h", a);
    wait_tx(40);
    got = pop_str(40);
    tests++;
    if (got != exp) begin fails++; $display("FAIL greet: got \"%s\" want \"%s\"", got, exp); end
  endtask

  // One region after its greeting: size, echo, payload from pl, ACK text, memory writes
  task automatic region(input logic [31:0] a);
    logic [31:0] sz, ea;
    logic [7:0]  b;
    logic [67:0] gw, ew;
    string got, exp;
    sz = pl.size();
    send_word(sz);
    wait_tx(4);
    for (int i = 0; i < 4; i++) begin
      b = (txq.size() > 0) ? txq.pop_front() : 8'hxx;
      tests++;
      if (b !== sz[(3-i)*8 +: 8]) begin
        fails++; $display("FAIL echo[%0d]: got %h want %h", i, b, sz[(3-i)*8 +: 8]);
      end
    end
    foreach (pl[i]) send_byte(pl[i]);
    wait_tx(57);
    got = pop_str(57);
    exp = $sformatf("finished write 0x%08h bytes starting from 0x%08h\n", sz, a);
    tests++;
    if (got != exp) begin fails++; $display("FAIL ack: got \"%s\" want \"%s\"", got, exp); end
    tests++;
    if (wrq.size() != pl.size()) begin
      fails++; $display("FAIL write_count: got %0d want %0d", wrq.size(), pl.size());
    end
    foreach (pl[i]) begin
      ea = a + i;
      ew = {ea[31:2], 2'b00, 4'(4'b0001 << ea[1:0]), {4{pl[i]}}};
      gw = (wrq.size() > 0) ? wrq.pop_front() : 68'hx;
      tests++;
      if (gw !== ew) begin fails++; $display("FAIL write[%0d]: got %h want %h", i, gw, ew); end
    end
  endtask

  task automatic finish_to_run;
    send_word(32'd0);
    repeat (5) @(negedge clk_i);
    tests++;
    if (done_o !== 1'b1 || core_reset_o !== 1'b0) begin
      fails++; $display("FAIL run: got done=%b core_reset=%b want 1/0", done_o, core_reset_o);
    end
  endtask

  task automatic test_reset;
    @(negedge clk_i); rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    tests++;
    if ({tx_valid_o, tx_data_o, mem_we_o, mem_addr_o, mem_be_o, mem_wd_o, core_reset_o, done_o} !==
        {1'b0, 8'h00, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_vals: got tv=%b td=%h we=%b a=%h be=%b wd=%h cr=%b d=%b", tx_valid_o,
               tx_data_o, mem_we_o, mem_addr_o, mem_be_o, mem_wd_o, core_reset_o, done_o);
    end
    txq.delete(); wrq.delete();
    rst_i = 1'b0;
    expect_greet(32'd0);
    repeat (300) @(negedge clk_i);
    tests++;
    if (txq.size() != 0 || core_reset_o !== 1'b1 || done_o !== 1'b0) begin
      fails++; $display("FAIL idle_after_greet: got extra=%0d cr=%b d=%b want 0/1/0",
                        txq.size(), core_reset_o, done_o);
    end
  endtask

  task automatic test_zero_size;
    do_reset();
    expect_greet(32'd0);
    pl.delete();
    region(32'd0);
    finish_to_run();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    repeat (50) @(negedge clk_i);
    tests++;
    if (txq.size() != 0 || wrq.size() != 0 || done_o !== 1'b1) begin
      fails++; $display("FAIL run_ignores_rx: got tx=%0d wr=%0d done=%b want 0/0/1",
                        txq.size(), wrq.size(), done_o);
    end
  endtask

  task automatic test_payload;
    logic [31:0] al[3];
    do_reset();
    expect_greet(32'd0);
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    region(32'd0);
    send_word(32'h0000_1002);
    expect_greet(32'h0000_1002);
    pl = '{8'($urandom), 8'($urandom)};
    region(32'h0000_1002);
    al[0] = $urandom | 32'd1;
    al[1] = $urandom | 32'h8000_0000;
    al[2] = 32'hFFFF_FFFD;
    for (int r = 0; r < 3; r++) begin
      send_word(al[r]);
      expect_greet(al[r]);
      pl.delete();
      repeat ($urandom_range(1, 10)) pl.push_back(8'($urandom));
      region(al[r]);
    end
    finish_to_run();
  endtask

  task automatic test_busy;
    int n0;
    logic [7:0] b;
    do_reset();
    wait_tx(10);
    @(negedge clk_i); hold_busy = 1'b1;
    @(negedge clk_i); n0 = txq.size();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    while (txq.size() == n0 && busy_cnt == 0 && n0 >= 0) begin
      repeat (480) @(negedge clk_i);
      break;
    end
    tests++;
    if (txq.size() != n0) begin
      fails++; $display("FAIL busy_hold: got %0d bytes want %0d", txq.size(), n0);
    end
    hold_busy = 1'b0;
    expect_greet(32'd0);
    pl.delete();
    b = 8'($urandom_range(1, 3));
    repeat (b) pl.push_back(8'($urandom));
    region(32'd0);
    finish_to_run();
  endtask

  task automatic test_rst_mid;
    logic [67:0] ew, gw;
    do_reset();
    expect_greet(32'd0);
    send_word(32'd8);
    wait_tx(4);
    txq.delete();
    pl.delete();
    for (int i = 0; i < 3; i++) begin pl.push_back(8'($urandom)); send_byte(pl[i]); end
    repeat (2) @(negedge clk_i);
    tests++;
    if (wrq.size() != 3) begin fails++; $display("FAIL pre_rst_writes: got %0d want 3", wrq.size()); end
    for (int i = 0; i < 3; i++) begin
      ew = {30'd0, 2'b00, 4'(4'b0001 << i), {4{pl[i]}}};
      gw = (wrq.size() > 0) ? wrq.pop_front() : 68'hx;
      tests++;
      if (gw !== ew) begin fails++; $display("FAIL pre_rst_write[%0d]: got %h want %h", i, gw, ew); end
    end
    @(negedge clk_i); rst_i = 1'b1;
    @(negedge clk_i);
    tests++;
    if (mem_we_o !== 1'b0 || core_reset_o !== 1'b1) begin
      fails++; $display("FAIL rst_mid: got we=%b cr=%b want 0/1", mem_we_o, core_reset_o);
    end
    repeat (2) @(negedge clk_i);
    txq.delete(); wrq.delete();
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) send_byte(8'($urandom));
    expect_greet(32'd0);
    tests++;
    if (wrq.size() != 0) begin fails++; $display("FAIL post_rst_writes: got %0d want 0", wrq.size()); end
    pl = '{8'($urandom), 8'($urandom)};
    region(32'd0);
    finish_to_run();
  endtask

  task automatic test_timeout;
    do_reset();
    expect_greet(32'd0);
`ifdef LOADER_TIMEOUT_EN
    repeat (990) @(negedge clk_i);
    tests++;
    if (done_o !== 1'b0) begin fails++; $display("FAIL timeout_early: got done=%b want 0", done_o); end
    repeat (20) @(negedge clk_i);
    tests++;
    if (done_o !== 1'b1 || core_reset_o !== 1'b0) begin
      fails++; $display("FAIL timeout_boot: got done=%b cr=%b want 1/0", done_o, core_reset_o);
    end
`else
    repeat (3000) @(negedge clk_i);
    tests++;
    if (done_o !== 1'b0 || core_reset_o !== 1'b1) begin
      fails++; $display("FAIL no_timeout: got done=%b cr=%b want 0/1", done_o, core_reset_o);
    end
`endif
  endtask

  task automatic test_rules;
    tests++;
    if (viol_busy != 0) begin fails++; $display("FAIL tx_while_busy: got %0d want 0", viol_busy); end
    tests++;
    if (viol_vw != 0) begin fails++; $display("FAIL tx_valid_width: got %0d want 0", viol_vw); end
    tests++;
    if (viol_wew != 0) begin fails++; $display("FAIL we_width: got %0d want 0", viol_wew); end
    tests++;
    if (viol_wecore != 0) begin fails++; $display("FAIL we_in_run: got %0d want 0", viol_wecore); end
  endtask

  initial begin
    test_reset();
    test_zero_size();
    test_payload();
    test_busy();
    test_rst_mid();
    test_timeout();
    test_rules();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
